// File: rtl/board_render_pkg.sv
// rtl/board_render_pkg.sv - shared cell type, glyph codes and saturating subtract for board_renderer
package board_render_pkg;
    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } cell_t;

    typedef enum logic [1:0] {
        RG_BG    = 2'd0,
        RG_BOARD = 2'd1,
        RG_FONT  = 2'd2
    } region_e;

    localparam logic [6:0] CH_ZERO  = 7'h30;
    localparam logic [6:0] CH_COLON = 7'h3A;
    localparam logic [6:0] CH_PLUS  = 7'h2B;

    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [15:0] b);
        return ({8'd0, a} > b) ? 8'({8'd0, a} - b) : 8'd0;
    endfunction
endpackage

// File: rtl/row_fetch_buf.sv
// rtl/row_fetch_buf.sv - hblank row fetch FSM feeding a shadow/active double row buffer
module row_fetch_buf #(
    parameter int BOARD_COLS = 10,
    parameter int BOARD_ROWS = 20,
    parameter int SQ         = 21
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_hs,
    input  logic [9:0]               i_draw_y,
    input  logic                     i_row_ack,
    input  logic [BOARD_COLS*16-1:0] i_row_data,
    output logic                     o_row_req,
    output logic [4:0]               o_row_idx,
    output logic [BOARD_COLS*16-1:0] o_active,
    output logic                     o_row_miss
);
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_SWAP = 2'd2;
    localparam logic [10:0] L_SQ    = 11'(SQ);
    localparam logic [10:0] L_ROWS  = 11'(BOARD_ROWS);

    logic [1:0]                r_state;
    logic                      r_req;
    logic [4:0]                r_idx;
    logic [BOARD_COLS*16-1:0]  r_shadow;
    logic [BOARD_COLS*16-1:0]  r_active;
    logic                      r_shadow_valid;
    logic                      r_miss;

    logic [10:0] w_y1;
    logic [10:0] w_next;
    logic        w_boundary;
    logic [4:0]  w_next_row;
    logic        w_take;

    assign w_y1       = {1'b0, i_draw_y} + 11'd1;
    assign w_next     = w_y1 / L_SQ;
    assign w_boundary = (w_y1 % L_SQ) == 11'd0;
    assign w_next_row = (i_draw_y >= 10'd479 || w_next >= L_ROWS) ? 5'd0 : w_next[4:0];
    assign w_take     = r_req & i_row_ack;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_req          <= 1'b0;
            r_idx          <= 5'd0;
            r_shadow       <= '0;
            r_active       <= '0;
            r_shadow_valid <= 1'b0;
            r_miss         <= 1'b0;
        end else begin
            // A request stays open across states; late data only ever lands in the shadow.
            if (w_take) begin
                r_shadow       <= i_row_data;
                r_shadow_valid <= 1'b1;
                r_req          <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_hs && w_boundary) begin
                        r_req   <= 1'b1;
                        r_idx   <= w_next_row;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_take || !i_hs)
                        r_state <= ST_SWAP;
                end
                ST_SWAP: begin
                    if (!i_hs) begin
                        if (r_shadow_valid) begin
                            r_active       <= r_shadow;
                            r_shadow_valid <= 1'b0;
                        end else begin
                            r_miss <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_row_req  = r_req;
    assign o_row_idx  = r_idx;
    assign o_active   = r_active;
    assign o_row_miss = r_miss;
endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - two-stage pixel colour pipeline: board tiles, score/timer text, clear popup
module board_renderer #(
    parameter int BOARD_COLS   = 10,
    parameter int BOARD_ROWS   = 20,
    parameter int SQ           = 21,
    parameter int LEFT_EDGE    = 213,
    parameter int NUM_DIGITS   = 4,
    parameter int POPUP_FRAMES = 60,
    parameter int SHADE_STEP   = 2
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic                     frame_clk,
    input  logic                     hs,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    output logic                     row_req,
    output logic [4:0]               row_idx,
    input  logic                     row_ack,
    input  logic [BOARD_COLS*16-1:0] row_data,
    input  logic [NUM_DIGITS*4-1:0]  score_digits,
    input  logic [11:0]              timer_digits,
    input  logic                     popup_trig,
    input  logic [7:0]               popup_val,
    input  logic [4:0]               popup_row,
    output logic [10:0]              font_addr,
    input  logic [7:0]               font_data,
    output logic [7:0]               Red,
    output logic [7:0]               Green,
    output logic [7:0]               Blue,
    output logic                     row_miss
);
    import board_render_pkg::*;

    localparam int RE   = LEFT_EDGE + BOARD_COLS*SQ;
    localparam int COLW = (BOARD_COLS > 1) ? $clog2(BOARD_COLS) : 1;
    localparam int PCW  = $clog2(POPUP_FRAMES + 1);
    localparam logic [10:0]    L_SQ        = 11'(SQ);
    localparam logic [10:0]    L_LE        = 11'(LEFT_EDGE);
    localparam logic [10:0]    L_RE        = 11'(RE);
    localparam logic [10:0]    L_BOARD_H   = 11'(BOARD_ROWS*SQ);
    localparam logic [10:0]    L_SCORE_END = 11'(RE + 8*NUM_DIGITS);
    localparam logic [10:0]    L_TIMER_X0  = 11'(LEFT_EDGE - 32);
    localparam logic [10:0]    L_POP_END   = 11'(RE + 24);
    localparam logic [PCW-1:0] POP_LAST    = PCW'(POPUP_FRAMES - 1);

    logic [BOARD_COLS*16-1:0] w_active;

    row_fetch_buf #(.BOARD_COLS(BOARD_COLS), .BOARD_ROWS(BOARD_ROWS), .SQ(SQ)) u_fetch (
        .i_clk      (Clk),
        .i_reset    (reset),
        .i_hs       (hs),
        .i_draw_y   (DrawY),
        .i_row_ack  (row_ack),
        .i_row_data (row_data),
        .o_row_req  (row_req),
        .o_row_idx  (row_idx),
        .o_active   (w_active),
        .o_row_miss (row_miss)
    );

    logic           r_pop_active;
    logic [7:0]     r_pop_val;
    logic [4:0]     r_pop_row;
    logic [PCW-1:0] r_pop_cnt;
    logic           r_frame_d;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_pop_active <= 1'b0;
            r_pop_val    <= 8'd0;
            r_pop_row    <= 5'd0;
            r_pop_cnt    <= '0;
            r_frame_d    <= 1'b0;
        end else begin
            r_frame_d <= frame_clk;
            if (popup_trig) begin
                r_pop_active <= 1'b1;
                r_pop_val    <= popup_val;
                r_pop_row    <= popup_row;
                r_pop_cnt    <= '0;
            end else if (r_pop_active && frame_clk && !r_frame_d) begin
                if (r_pop_cnt == POP_LAST) begin
                    r_pop_active <= 1'b0;
                    r_pop_cnt    <= '0;
                end else begin
                    r_pop_cnt <= r_pop_cnt + 1'b1;
                end
            end
        end
    end

    logic [10:0]     w_x, w_y, w_bx, w_xoff, w_yoff, w_ytop, w_sx, w_pop_y0;
    logic [4:0]      w_tx;
    logic [3:0]      w_py;
    logic [COLW-1:0] w_col;
    logic            w_in_board, w_in_score, w_in_timer, w_in_pop, w_border, w_bg_black;

    assign w_x        = {1'b0, DrawX};
    assign w_y        = {1'b0, DrawY};
    assign w_bx       = w_x - L_LE;
    assign w_col      = COLW'(w_bx / L_SQ);
    assign w_xoff     = w_bx % L_SQ;
    assign w_yoff     = w_y % L_SQ;
    assign w_ytop     = w_y - w_yoff;
    assign w_sx       = w_x - L_RE;
    assign w_tx       = 5'(w_x - L_TIMER_X0);
    assign w_pop_y0   = {6'd0, r_pop_row} * L_SQ;
    assign w_py       = 4'(w_y - w_pop_y0);
    assign w_in_board = (w_x >= L_LE) && (w_x < L_RE) && (w_y < L_BOARD_H);
    assign w_in_score = (w_x >= L_RE) && (w_x < L_SCORE_END) && (w_y < 11'd16);
    assign w_in_timer = (w_x >= L_TIMER_X0) && (w_x < L_LE) && (w_y < 11'd16);
    assign w_in_pop   = r_pop_active && (w_x >= L_RE) && (w_x < L_POP_END) &&
                        (w_y >= w_pop_y0) && (w_y < w_pop_y0 + 11'd16);
    assign w_border   = (w_xoff == 11'd0) || (w_xoff == L_SQ - 11'd1) ||
                        (w_yoff == 11'd0) || (w_yoff == L_SQ - 11'd1);
    assign w_bg_black = ((w_x % L_SQ) == 11'd0) || (w_yoff == 11'd0);

    logic [6:0] w_char;
    logic [3:0] w_line;
    logic [3:0] w_sdig;
    logic [2:0] w_bitsel;
    logic       w_font_hit;

    // Text fields share one ROM port, so the higher-priority field picks the character.
    always_comb begin
        w_sdig = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (w_sx[10:3] == 8'(i)) w_sdig = score_digits[(NUM_DIGITS-1-i)*4 +: 4];
        w_char     = CH_ZERO;
        w_line     = w_y[3:0];
        w_bitsel   = w_sx[2:0];
        w_font_hit = 1'b1;
        if (w_in_score) begin
            w_char = CH_ZERO + {3'd0, w_sdig};
        end else if (w_in_timer) begin
            w_bitsel = w_tx[2:0];
            case (w_tx[4:3])
                2'd0:    w_char = CH_ZERO + {3'd0, timer_digits[11:8]};
                2'd1:    w_char = CH_COLON;
                2'd2:    w_char = CH_ZERO + {3'd0, timer_digits[7:4]};
                default: w_char = CH_ZERO + {3'd0, timer_digits[3:0]};
            endcase
        end else if (w_in_pop) begin
            w_line = w_py;
            case (w_sx[4:3])
                2'd0:    w_char = CH_PLUS;
                2'd1:    w_char = CH_ZERO + {3'd0, r_pop_val[7:4]};
                default: w_char = CH_ZERO + {3'd0, r_pop_val[3:0]};
            endcase
        end else begin
            w_font_hit = 1'b0;
        end
    end

    assign font_addr = {w_char, w_line};

    region_e         r_s1_region;
    logic [COLW-1:0] r_s1_col;
    logic            r_s1_border;
    logic            r_s1_bg_black;
    logic [10:0]     r_s1_ytop;
    logic [2:0]      r_s1_bit;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_s1_region   <= RG_BG;
            r_s1_col      <= '0;
            r_s1_border   <= 1'b0;
            r_s1_bg_black <= 1'b0;
            r_s1_ytop     <= 11'd0;
            r_s1_bit      <= 3'd0;
        end else begin
            r_s1_region   <= w_in_board ? RG_BOARD : (w_font_hit ? RG_FONT : RG_BG);
            r_s1_col      <= w_col;
            r_s1_border   <= w_border;
            r_s1_bg_black <= w_bg_black;
            r_s1_ytop     <= w_ytop;
            r_s1_bit      <= w_bitsel;
        end
    end

    cell_t       w_cell;
    logic        w_empty;
    logic        w_font_pix;
    logic [15:0] w_shade;
    logic        w_unused_pad;

    always_comb begin
        w_cell = '0;
        for (int i = 0; i < BOARD_COLS; i++)
            if (r_s1_col == COLW'(i)) w_cell = w_active[i*16 +: 16];
    end

    assign w_empty      = (w_cell.r == 4'd0) && (w_cell.g == 4'd0);
    assign w_font_pix   = font_data[3'd7 - r_s1_bit];
    assign w_shade      = 16'(SHADE_STEP) * {5'd0, r_s1_ytop};
    assign w_unused_pad = ^w_cell.pad;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            Red   <= 8'd0;
            Green <= 8'd0;
            Blue  <= 8'd0;
        end else begin
            case (r_s1_region)
                RG_BOARD: begin
                    if (r_s1_border && !w_empty) begin
                        {Red, Green, Blue} <= 24'd0;
                    end else begin
                        Red   <= sat_sub8({w_cell.r, 4'd0}, w_shade);
                        Green <= sat_sub8({w_cell.g, 4'd0}, w_shade);
                        Blue  <= sat_sub8({w_cell.b, 4'd0}, w_shade);
                    end
                end
                RG_FONT: {Red, Green, Blue} <= {24{w_font_pix}};
                default: {Red, Green, Blue} <= r_s1_bg_black ? 24'd0 : 24'h060606;
            endcase
        end
    end
endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - directed bench for board_renderer with a pixel scoreboard and font ROM model
module tb_board_renderer;
    logic         Clk = 1'b0;
    logic         reset, frame_clk, hs, row_ack, popup_trig;
    logic [9:0]   DrawX, DrawY;
    logic         row_req, row_miss;
    logic [4:0]   row_idx, popup_row;
    logic [159:0] row_data;
    logic [15:0]  score_digits;
    logic [11:0]  timer_digits;
    logic [7:0]   popup_val, font_data, Red, Green, Blue;
    logic [10:0]  font_addr;

    board_renderer dut (
        .Clk(Clk), .reset(reset), .frame_clk(frame_clk), .hs(hs),
        .DrawX(DrawX), .DrawY(DrawY), .row_req(row_req), .row_idx(row_idx),
        .row_ack(row_ack), .row_data(row_data), .score_digits(score_digits),
        .timer_digits(timer_digits), .popup_trig(popup_trig), .popup_val(popup_val),
        .popup_row(popup_row), .font_addr(font_addr), .font_data(font_data),
        .Red(Red), .Green(Green), .Blue(Blue), .row_miss(row_miss)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] fm(input logic [10:0] a);
        logic [15:0] t;
        t = {5'd0, a} * 16'd29;
        return t[7:0] ^ {a[10:4], 1'b1};
    endfunction

    always @(posedge Clk) font_data <= fm(font_addr);

    function automatic logic [23:0] glyph(input logic [6:0] ch, input logic [3:0] ln, input logic [2:0] off);
        logic [7:0] b;
        b = fm({ch, ln});
        return b[3'd7 - off] ? 24'hFFFFFF : 24'h000000;
    endfunction

    typedef struct {
        logic [23:0] exp;
        int          due;
        string       tag;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        cyc++;
        #1;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            chk(e.tag, {8'd0, Red, Green, Blue}, {8'd0, e.exp});
        end
    endtask

    task automatic px(input int x, input int y, input logic [23:0] exp, input string tag);
        DrawX = 10'(x);
        DrawY = 10'(y);
        sbq.push_back('{exp: exp, due: cyc + 2, tag: tag});
        tick();
    endtask

    task automatic flush();
        tick();
        tick();
    endtask

    task automatic fedge();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] d;
        logic [6:0] ch;
        reset = 1'b1; frame_clk = 1'b0; hs = 1'b0; row_ack = 1'b0; popup_trig = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; row_data = '0; score_digits = 16'h1234;
        timer_digits = 12'h159; popup_val = 8'd0; popup_row = 5'd0;
        tick();
        tick();
        chk("reset row_req", {31'd0, row_req}, 32'd0);
        chk("reset row_idx", {27'd0, row_idx}, 32'd0);
        chk("reset rgb", {8'd0, Red, Green, Blue}, 32'd0);
        chk("reset row_miss", {31'd0, row_miss}, 32'd0);
        reset = 1'b0;
        tick();

        // Fetch block row 1 at the end of line 20.
        DrawX = 10'd700; DrawY = 10'd20; hs = 1'b1;
        tick();
        chk("fetch1 row_req", {31'd0, row_req}, 32'd1);
        chk("fetch1 row_idx", {27'd0, row_idx}, 32'd1);
        row_data = '0;
        row_data[15:0]  = 16'h0F00;
        row_data[31:16] = 16'h0088;
        row_data[47:32] = 16'h0007;
        row_ack = 1'b1;
        tick();
        row_ack = 1'b0;
        chk("fetch1 req dropped", {31'd0, row_req}, 32'd0);
        hs = 1'b0;
        tick();
        chk("fetch1 no miss", {31'd0, row_miss}, 32'd0);

        px(214, 25, 24'hC60000, "cell0 shaded");
        px(213, 25, 24'h000000, "cell0 left border");
        px(233, 25, 24'h000000, "cell0 right border");
        px(240, 25, 24'h005656, "cell1 shaded");
        px(255, 25, 24'h000046, "empty cell border not black");
        px(256, 25, 24'h000046, "empty cell blue");
        px(214, 5,  24'hF00000, "top block row unshaded");
        px(214, 418, 24'h000000, "bottom row saturates");
        px(214, 421, 24'h060606, "below board grey");
        px(100, 100, 24'h060606, "bg grey");
        px(105, 100, 24'h000000, "bg grid x");
        px(423, 30, 24'h060606, "right of board bg");
        flush();

        // Block row 10 with R nibble 1: 0x10 - 2*210 must clamp at zero.
        DrawX = 10'd700; DrawY = 10'd209; hs = 1'b1;
        tick();
        chk("fetch10 row_idx", {27'd0, row_idx}, 32'd10);
        row_data = '0;
        row_data[15:0] = 16'h0100;
        row_ack = 1'b1;
        tick();
        row_ack = 1'b0;
        hs = 1'b0;
        tick();
        px(214, 215, 24'h000000, "shade saturates no wrap");
        px(214, 5, 24'h100000, "row10 data at ytop 0");
        flush();

        // No ack during hblank: miss is flagged and the late data stays in the shadow.
        DrawX = 10'd700; DrawY = 10'd230; hs = 1'b1;
        tick();
        chk("fetch11 row_idx", {27'd0, row_idx}, 32'd11);
        hs = 1'b0;
        tick();
        tick();
        chk("miss sticky", {31'd0, row_miss}, 32'd1);
        chk("miss req held", {31'd0, row_req}, 32'd1);
        row_data = '0;
        row_data[15:0] = 16'h0F00;
        row_ack = 1'b1;
        tick();
        row_ack = 1'b0;
        chk("late ack clears req", {31'd0, row_req}, 32'd0);
        px(214, 5, 24'h100000, "stale row displayed");
        flush();

        // Score and timer text.
        DrawX = 10'd423; DrawY = 10'd3;
        #1;
        chk("score font_addr", {21'd0, font_addr}, 32'h313);
        for (int x = 423; x < 455; x++) begin
            d  = 4'(16'h1234 >> (4 * (3 - (x - 423) / 8)));
            ch = 7'h30 + {3'd0, d};
            px(x, 3, glyph(ch, 4'd3, 3'((x - 423) % 8)), $sformatf("score x=%0d", x));
        end
        for (int x = 181; x < 213; x++) begin
            case ((x - 181) / 8)
                0:       ch = 7'h31;
                1:       ch = 7'h3A;
                2:       ch = 7'h35;
                default: ch = 7'h39;
            endcase
            px(x, 7, glyph(ch, 4'd7, 3'((x - 181) % 8)), $sformatf("timer x=%0d", x));
        end
        flush();

        // Popup "+05" at block row 3 (Y 63..78).
        popup_val = 8'h05; popup_row = 5'd3; popup_trig = 1'b1;
        tick();
        popup_trig = 1'b0;
        px(423, 63, glyph(7'h2B, 4'd0, 3'd0), "popup plus line0");
        for (int x = 423; x < 447; x++) begin
            ch = ((x - 423) < 8) ? 7'h2B : (((x - 423) < 16) ? 7'h30 : 7'h35);
            px(x, 70, glyph(ch, 4'd7, 3'((x - 423) % 8)), $sformatf("popup x=%0d", x));
        end
        px(446, 78, glyph(7'h35, 4'd15, 3'd7), "popup last line");
        px(423, 79, 24'h060606, "popup below");
        px(423, 62, 24'h060606, "popup above");
        px(447, 70, 24'h060606, "popup right");
        flush();
        for (int i = 0; i < 59; i++) fedge();
        px(423, 64, glyph(7'h2B, 4'd1, 3'd0), "popup after 59 edges");
        fedge();
        px(423, 64, 24'h060606, "popup gone after 60 edges");
        flush();

        // Retrigger at edge 30 restarts with the new value.
        popup_val = 8'h05; popup_trig = 1'b1;
        tick();
        popup_trig = 1'b0;
        for (int i = 0; i < 30; i++) fedge();
        popup_val = 8'h42; popup_trig = 1'b1;
        tick();
        popup_trig = 1'b0;
        for (int i = 0; i < 59; i++) fedge();
        px(431, 70, glyph(7'h34, 4'd7, 3'd0), "retrigger still visible");
        fedge();
        px(431, 70, 24'h060606, "retrigger expired");
        flush();

        // Trigger coinciding with the expiring edge keeps the popup alive.
        popup_trig = 1'b1;
        tick();
        popup_trig = 1'b0;
        for (int i = 0; i < 59; i++) fedge();
        frame_clk = 1'b1; popup_trig = 1'b1;
        tick();
        frame_clk = 1'b0; popup_trig = 1'b0;
        tick();
        px(423, 64, glyph(7'h2B, 4'd1, 3'd0), "trigger wins over expiry");
        flush();

        // Asynchronous reset in the middle of a fetch.
        DrawX = 10'd700; DrawY = 10'd20; hs = 1'b1;
        tick();
        chk("prereset row_req", {31'd0, row_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset row_req", {31'd0, row_req}, 32'd0);
        chk("async reset rgb", {8'd0, Red, Green, Blue}, 32'd0);
        chk("async reset row_miss", {31'd0, row_miss}, 32'd0);
        hs = 1'b0;
        tick();
        reset = 1'b0;
        row_ack = 1'b1;
        tick();
        row_ack = 1'b0;
        chk("late ack ignored req", {31'd0, row_req}, 32'd0);
        px(214, 5, 24'h000000, "active row cleared by reset");
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
